// File: rtl/wb_regfile_if.sv
// MEM/WB-to-write-back bus for wb_regfile: write-back controls and data in,
// ID-stage read ports, forwarding value and commit counter out.
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              RegWrite_i;
   logic              MemtoReg_i;
   logic [DATA_W-1:0] data_i;
   logic [DATA_W-1:0] addr_i;
   logic [ADDR_W-1:0] RegDst_i;
   logic [ADDR_W-1:0] RSaddr_i;
   logic [ADDR_W-1:0] RTaddr_i;
   logic [DATA_W-1:0] RSdata_o;
   logic [DATA_W-1:0] RTdata_o;
   logic [DATA_W-1:0] WBdata_o;
   logic              WBvalid_o;
   logic [31:0]       WBcnt_o;

   // The pipeline/ID side drives indices and write-back payload.
   modport master (
      output RegWrite_i, MemtoReg_i, data_i, addr_i, RegDst_i, RSaddr_i, RTaddr_i,
      input  RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcnt_o
   );

   modport slave (
      input  RegWrite_i, MemtoReg_i, data_i, addr_i, RegDst_i, RSaddr_i, RTaddr_i,
      output RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcnt_o
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 register file with two combinational read ports.
// Define WB_REGFILE_BYPASS_EN to make reads of the register being written return the new value.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   wb_regfile_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [31:0]       wb_cnt;
   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   wire  [31:0]       cnt_next = wb_cnt + 32'd1;

   // Gating with rst_i keeps WBvalid_o low during reset; r0 is never a commit target.
   always_comb begin
      wb_data  = bus.MemtoReg_i ? bus.data_i : bus.addr_i;
      wb_valid = bus.RegWrite_i & (bus.RegDst_i != '0) & rst_i;
   end

   // An unknown write enable evaluates false in the if, so the array is left untouched.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         wb_cnt <= '0;
      end else if (wb_valid) begin
         regs[bus.RegDst_i] <= wb_data;
         wb_cnt             <= cnt_next;
      end
   end

   always_comb begin
      rs_data = regs[bus.RSaddr_i];
      rt_data = regs[bus.RTaddr_i];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_valid && (bus.RSaddr_i == bus.RegDst_i)) begin
         rs_data = wb_data;
      end
      if (wb_valid && (bus.RTaddr_i == bus.RegDst_i)) begin
         rt_data = wb_data;
      end
`endif
      if (!rst_i || (bus.RSaddr_i == '0)) begin
         rs_data = '0;
      end
      if (!rst_i || (bus.RTaddr_i == '0)) begin
         rt_data = '0;
      end
   end

   assign bus.RSdata_o  = rs_data;
   assign bus.RTdata_o  = rt_data;
   assign bus.WBdata_o  = wb_data;
   assign bus.WBvalid_o = wb_valid;
   assign bus.WBcnt_o   = wb_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios, randomized traffic
// against an array-based reference model, and a counter wrap via a forced increment.
module tb_wb_regfile;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model_regs [32];
   logic [31:0] model_cnt;

   always #5 clk_i = ~clk_i;

   wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   function automatic logic [31:0] exp_wbdata();
      return bus.MemtoReg_i ? bus.data_i : bus.addr_i;
   endfunction

   function automatic logic exp_commit();
      return rst_i && bus.RegWrite_i && (bus.RegDst_i != 5'd0);
   endfunction

   // Reference read: zero in reset or for r0, write-through only in bypass builds.
   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (!rst_i || idx == 5'd0) return 32'd0;
      if (BYPASS && exp_commit() && idx == bus.RegDst_i) return exp_wbdata();
      return model_regs[idx];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rw, input logic m2r,
                                input logic [31:0] data, input logic [31:0] addr,
                                input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
      rst_i          = rst;
      bus.RegWrite_i = rw;
      bus.MemtoReg_i = m2r;
      bus.data_i     = data;
      bus.addr_i     = addr;
      bus.RegDst_i   = dst;
      bus.RSaddr_i   = rs;
      bus.RTaddr_i   = rt;
      #1;
   endtask

   task automatic checkOutput(input string tag);
      check_val({tag, "/rs"},    bus.RSdata_o, exp_read(bus.RSaddr_i));
      check_val({tag, "/rt"},    bus.RTdata_o, exp_read(bus.RTaddr_i));
      check_val({tag, "/wbdat"}, bus.WBdata_o, exp_wbdata());
      check_val({tag, "/wbval"}, {31'd0, bus.WBvalid_o}, {31'd0, exp_commit()});
      check_val({tag, "/cnt"},   bus.WBcnt_o, model_cnt);
   endtask

   // Advance one clock, applying the model's view of what that edge commits.
   task automatic tick();
      logic        c;
      logic        r;
      logic [31:0] d;
      logic [4:0]  dst;
      c   = exp_commit();
      r   = rst_i;
      d   = exp_wbdata();
      dst = bus.RegDst_i;
      @(posedge clk_i);
      if (!r) begin
         foreach (model_regs[i]) model_regs[i] = 32'd0;
         model_cnt = 32'd0;
      end else if (c) begin
         model_regs[dst] = d;
         model_cnt       = model_cnt + 32'd1;
      end
      @(negedge clk_i);
   endtask

   initial begin
      foreach (model_regs[i]) model_regs[i] = 32'd0;
      model_cnt = 32'd0;

      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h11, 5'd5, 5'd5, 5'd0);
      tick();
      checkOutput("reset1");
      tick();
      checkOutput("reset2");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h11, 5'd5, 5'd5, 5'd5);
      checkOutput("rst_release");
      check_val("reset_r5", bus.RSdata_o, 32'd0);
      check_val("reset_cnt", bus.WBcnt_o, 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 32'h1234, 32'hDEADBEEF, 5'd8, 5'd0, 5'd0);
      checkOutput("alu_w");
      check_val("alu_wbdata", bus.WBdata_o, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd8);
      checkOutput("alu_r");
      check_val("alu_rs", bus.RSdata_o, 32'hDEADBEEF);
      check_val("alu_cnt", bus.WBcnt_o, 32'd1);

      applyStimulus(1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5'd31, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd31);
      checkOutput("load_r");
      check_val("load_rt", bus.RTdata_o, 32'hCAFEF00D);

      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      checkOutput("r0_w");
      check_val("r0_wbvalid", {31'd0, bus.WBvalid_o}, 32'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      check_val("r0_rs", bus.RSdata_o, 32'd0);
      check_val("r0_cnt", bus.WBcnt_o, 32'd2);

      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h1, 5'd3, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h2, 5'd3, 5'd3, 5'd3);
      checkOutput("hazard");
      check_val("hazard_rs", bus.RSdata_o, BYPASS ? 32'h2 : 32'h1);
      check_val("hazard_rt", bus.RTdata_o, BYPASS ? 32'h2 : 32'h1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
      check_val("hazard_after", bus.RSdata_o, 32'h2);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h55, 5'd4, 5'd4, 5'd4);
         checkOutput("disabled");
         check_val("dis_wbdata", bus.WBdata_o, 32'h55);
         check_val("dis_cnt", bus.WBcnt_o, 32'd4);
         tick();
      end
      check_val("dis_r4", bus.RSdata_o, 32'd0);

      for (int k = 0; k < 300; k++) begin
         logic [4:0] dst;
         logic [4:0] rs;
         dst = 5'($urandom_range(0, 31));
         rs  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 29) != 0), 1'($urandom), 1'($urandom),
                       $urandom, $urandom, dst, rs, 5'($urandom_range(0, 31)));
         checkOutput("rand");
         tick();
      end

      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'hA5A5, 5'd9, 5'd9, 5'd0);
      force dut.cnt_next = 32'hFFFFFFFF;
      model_cnt = 32'hFFFFFFFE;
      tick();
      release dut.cnt_next;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h5A5A, 5'd10, 5'd9, 5'd10);
      check_val("wrap_max", bus.WBcnt_o, 32'hFFFFFFFF);
      checkOutput("wrap1");
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd9);
      check_val("wrap_zero", bus.WBcnt_o, 32'd0);
      checkOutput("wrap2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
